latch_bist: RTL

Built-in self-test sequencer for the level-sensitive D latch in the sequential library. It drives the latch's `d`/`en` inputs through a fixed eight-step vector schedule and samples the latch's `q` output. It then compares `q` against a reference model and reports pass/fail, the error count and the first failing step. It sits beside a latch instance as the stimulus-and-check end of the `d`/`en`/`q` interface, so latches can be qualified in hardware without a simulation bench.

---
 rtl/latch_bist_pkg.sv | 18 +
 rtl/latch_bist_sync_2ff.sv | 26 ++
 rtl/latch_bist.sv | 108 ++++++++++
 3 files changed

// File: rtl/latch_bist_pkg.sv
// Shared constants for the D-latch BIST sequencer: FSM states and the
// eight-step stimulus/expected-response schedule (bit index = step).
package latch_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_STEPS = 8;

    // Steps 0..7: d = 0,0,1,1,0,0,1,1  en = 1,0,0,1,1,0,0,1  q = 0,0,0,1,0,0,0,1
    localparam logic [NUM_STEPS-1:0] D_VEC  = 8'b1100_1100;
    localparam logic [NUM_STEPS-1:0] EN_VEC = 8'b1001_1001;
    localparam logic [NUM_STEPS-1:0] Q_VEC  = 8'b1000_1000;

endpackage

// File: rtl/latch_bist_sync_2ff.sv
// Two-flop synchronizer bringing the latch output into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // NOTE: flops use non-blocking assignments so both stages sample the
    // pre-edge values; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/latch_bist.sv
// BIST sequencer for a level-sensitive D latch: drives d/en through a fixed
// schedule, checks the synchronized q once per step, reports pass/errors.
module latch_bist
    import latch_bist_pkg::*;
#(
    parameter int STEP_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       q_in,
    output logic       d_out,
    output logic       en_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_step
);

    localparam logic [7:0] LAST_CYCLE = 8'(STEP_CYCLES - 1);
    localparam logic [3:0] MAX_ERRS   = 4'(NUM_STEPS);

    state_t     r_state;
    logic [2:0] r_step;
    logic [7:0] r_cycle;

    logic       w_q_sync;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    sync_2ff u_sync_q (
        .clk     (clk),
        .rst     (rst),
        .i_async (q_in),
        .o_sync  (w_q_sync)
    );

    always_comb begin
        w_mismatch = (w_q_sync != Q_VEC[r_step]);
        w_err_next = err_count;
        if (w_mismatch && (err_count < MAX_ERRS)) begin
            w_err_next = err_count + 4'd1;
        end
    end

    // The start edge counts as cycle 0 of step 0, so the counter is loaded
    // with 1: compare lands on the step's last edge, the vector change on
    // the following edge (counter == 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_step    <= 3'd0;
            r_cycle   <= 8'd0;
            d_out     <= 1'b0;
            en_out    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_step <= 3'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_step    <= 3'd0;
                        r_cycle   <= 8'd1;
                        d_out     <= D_VEC[0];
                        en_out    <= EN_VEC[0];
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= 4'd0;
                        fail_step <= 3'd0;
                    end
                end
                RUN: begin
                    if (r_cycle == LAST_CYCLE) begin
                        r_cycle   <= 8'd0;
                        err_count <= w_err_next;
                        if (w_mismatch && (err_count == 4'd0)) begin
                            fail_step <= r_step;
                        end
                    end else if (r_cycle == 8'd0) begin
                        r_cycle <= 8'd1;
                        if (r_step == 3'(NUM_STEPS - 1)) begin
                            r_state <= DONE;
                            d_out   <= 1'b0;
                            en_out  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_count == 4'd0);
                        end else begin
                            r_step <= r_step + 3'd1;
                            d_out  <= D_VEC[r_step + 3'd1];
                            en_out <= EN_VEC[r_step + 3'd1];
                        end
                    end else begin
                        r_cycle <= r_cycle + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
